// File: rtl/pcpi_pkg.sv
// pcpi_pkg: shared types and field positions for the PCPI accelerator dispatcher
package pcpi_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
  localparam int OPC_MSB = 6;
  localparam int F3_LSB = 12;
  localparam int F3_MSB = 14;
  localparam int F7_LSB = 25;
  localparam int F7_MSB = 31;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pcpi_dispatch_if.sv
// pcpi_dispatch_if: PCPI core port plus the shared accelerator-unit bus
interface pcpi_dispatch_if import pcpi_pkg::*; #(
  parameter int N_UNITS = 4
);
  logic                    pcpi_valid;
  logic [XLEN-1:0]         pcpi_insn;
  logic [XLEN-1:0]         pcpi_rs1;
  logic [XLEN-1:0]         pcpi_rs2;
  logic                    pcpi_wr;
  logic [XLEN-1:0]         pcpi_rd;
  logic                    pcpi_wait;
  logic                    pcpi_ready;
  logic [N_UNITS-1:0]      u_req;
  logic [2:0]              u_op;
  logic [XLEN-1:0]         u_a;
  logic [XLEN-1:0]         u_b;
  logic [N_UNITS-1:0]      u_ack;
  logic [N_UNITS-1:0]      u_done;
  logic [XLEN*N_UNITS-1:0] u_res;
  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, u_ack, u_done, u_res,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, u_req, u_op, u_a, u_b
  );
  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, u_ack, u_done, u_res,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, u_req, u_op, u_a, u_b
  );
endinterface

// File: rtl/pcpi_decode.sv
// pcpi_decode: combinational claim check and unit selection from the instruction word
module pcpi_decode import pcpi_pkg::*; #(
  parameter int N_UNITS = 4,
  parameter logic [6:0] OPCODE = OPCODE_CUSTOM0,
  localparam int IDX_W = idx_w(N_UNITS)
) (
  input  logic [XLEN-1:0]  insn,
  output logic             claim,
  output logic [IDX_W-1:0] idx,
  output logic [2:0]       op
);
  logic unused_fields;
  assign claim = insn[OPC_MSB:0] == OPCODE && 32'(insn[F7_MSB:F7_LSB]) < 32'(N_UNITS);
  assign idx = insn[F7_LSB +: IDX_W];
  assign op = insn[F3_MSB:F3_LSB];
  assign unused_fields = ^{insn[F7_LSB-1:F3_MSB+1], insn[F3_LSB-1:OPC_MSB+1]};
endmodule

// File: rtl/pcpi_dispatch.sv
// pcpi_dispatch: routes custom-0 PCPI instructions to one of N_UNITS accelerators.
// Define PCPI_DISPATCH_TIMEOUT_EN to force completion after TIMEOUT busy cycles.
module pcpi_dispatch import pcpi_pkg::*; #(
  parameter int N_UNITS = 4,
  parameter logic [6:0] OPCODE = OPCODE_CUSTOM0,
  parameter int TIMEOUT = 64
) (
  input  logic pcpi_clock,
  input  logic pcpi_reset,
`ifdef PCPI_DISPATCH_TIMEOUT_EN
  output logic timeout_flag,
`endif
  pcpi_dispatch_if.slave bus
);
  localparam int IDX_W = idx_w(N_UNITS);
  state_e state_q, state_d;
  logic claim, wait_q, wr_q, ack_sel, done_sel, busy, finish, expire;
  logic [IDX_W-1:0] idx_d, idx_q;
  logic [2:0] op_d, op_q;
  logic [XLEN-1:0] a_q, b_q, res_q, res_sel;
  pcpi_decode #(.N_UNITS(N_UNITS), .OPCODE(OPCODE)) u_decode (
    .insn(bus.pcpi_insn), .claim(claim), .idx(idx_d), .op(op_d)
  );
  assign busy = state_q == ISSUE || state_q == WAIT;
  assign ack_sel = bus.u_ack[idx_q];
  assign done_sel = bus.u_done[idx_q];
  assign res_sel = bus.u_res[32'(idx_q)*XLEN +: XLEN];
  // done counts in ISSUE only alongside the ack, which covers the same-cycle shortcut
  assign finish = bus.pcpi_valid && done_sel && (state_q == WAIT || (state_q == ISSUE && ack_sel));
`ifdef PCPI_DISPATCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic flag_q;
  assign expire = busy && bus.pcpi_valid && !finish && cnt_q == CNT_W'(TIMEOUT - 1);
  assign timeout_flag = flag_q;
  always_ff @(posedge pcpi_clock)
    if (!pcpi_reset) begin
      cnt_q <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q <= state_q == IDLE ? '0 : busy ? cnt_q + 1'b1 : cnt_q;
      flag_q <= flag_q | expire;
    end
`else
  localparam int unused_timeout = TIMEOUT;
  assign expire = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        state_d = bus.pcpi_valid && claim ? ISSUE : IDLE;
      ISSUE, WAIT: state_d = !bus.pcpi_valid ? IDLE : finish || expire ? RESP : state_q == ISSUE && ack_sel ? WAIT : state_q;
      RESP:        state_d = IDLE;
    endcase
  end
  always_ff @(posedge pcpi_clock)
    if (!pcpi_reset) begin
      state_q <= IDLE;
      wait_q <= 1'b0;
      wr_q <= 1'b0;
      idx_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= state_d == ISSUE || state_d == WAIT;
      if (state_q == IDLE && state_d == ISSUE) begin
        idx_q <= idx_d;
        op_q <= op_d;
        a_q <= bus.pcpi_rs1;
        b_q <= bus.pcpi_rs2;
      end
      if (finish) begin
        res_q <= res_sel;
        wr_q <= 1'b1;
      end else if (expire) begin
        res_q <= '0;
        wr_q <= 1'b0;
      end
    end
  assign bus.pcpi_wait = wait_q;
  assign bus.pcpi_ready = state_q == RESP;
  assign bus.pcpi_wr = state_q == RESP && wr_q;
  assign bus.pcpi_rd = state_q == RESP ? res_q : '0;
  assign bus.u_req = state_q == ISSUE ? N_UNITS'(1) << idx_q : '0;
  assign bus.u_op = op_q;
  assign bus.u_a = a_q;
  assign bus.u_b = b_q;
endmodule

// File: doc/pcpi_dispatch.md
PCPI_DISPATCH -- requirements
Module: pcpi_dispatch

Interface
REQ-001 Parameter: N_UNITS, 4, number of accelerator units sharing the PCPI port (1..8).
REQ-002 Parameter: OPCODE, 7'b0001011, custom-0 major opcode claimed by this block.
REQ-003 Parameter: TIMEOUT, 64, cycles allowed in WAIT before forced completion (timeout build only).
REQ-004 The block SHALL use a single clock, and reset SHALL be synchronous and active-low:
 - pcpi_clock  in  1  sole clock, rising edge.
 - pcpi_reset  in  1  synchronous reset, active-low.
REQ-005 PCPI side:
 - pcpi_valid  in  1  instruction offered.
 - pcpi_insn  in  32  instruction word.
 - pcpi_rs1  in  32  operand A.
 - pcpi_rs2  in  32  operand B.
 - pcpi_wr  out  1  write rd.
 - pcpi_rd  out  32  result.
 - pcpi_wait  out  1  instruction claimed, result pending.
 - pcpi_ready  out  1  completion strobe.
REQ-006 Unit side:
 - u_req  out  N_UNITS  one-hot request.
 - u_op  out  3  funct3.
 - u_a  out  32  latched rs1.
 - u_b  out  32  latched rs2.
 - u_ack  in  N_UNITS  request accepted.
 - u_done  in  N_UNITS  result valid.
 - u_res  in  32*N_UNITS  results; unit i occupies bits [32i+31:32i].

Function
REQ-007 Claim condition: insn[6:0]==OPCODE and insn[31:25]<N_UNITS; the unit index is insn[31:25].
REQ-008 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-009 IDLE: on pcpi_valid with claim, latch rs1, rs2, funct3 and index, then go to ISSUE; a non-claimed insn leaves all outputs low, so the core traps.
REQ-010 ISSUE: drive u_req[idx]=1 with stable u_a, u_b and u_op; hold until u_ack[idx]=1, then go to WAIT.
REQ-011 u_ack and u_done may assert in the same cycle as u_req; the FSM then goes directly to RESP and captures the result.
REQ-012 WAIT: when u_done[idx]=1, capture the u_res slice and go to RESP; u_done and u_ack of other units are ignored.
REQ-013 RESP: pcpi_ready=1 and pcpi_wr=1 for exactly one cycle with pcpi_rd equal to the captured result, then go to IDLE.
REQ-014 pcpi_wait SHALL be registered: high in ISSUE and WAIT, low in IDLE and RESP.
REQ-015 pcpi_rd SHALL be 0 whenever pcpi_ready=0.
REQ-016 Minimum latency: valid sampled at cycle 0, u_req at cycle 1 (ack+done at cycle 1), pcpi_ready at cycle 2.
REQ-017 Abort: if pcpi_valid=0 while in ISSUE or WAIT, return to IDLE next cycle, drop u_req, and discard any result.
REQ-018 One instruction is in flight at a time; pcpi_valid is ignored outside IDLE.
REQ-019 No re-dispatch: the cycle after RESP is IDLE, and pcpi_valid is expected low there per PCPI protocol.

Reset
REQ-020 On pcpi_reset=0 at a clock edge: state=IDLE, u_req=0, pcpi_ready=0, pcpi_wr=0, pcpi_wait=0, pcpi_rd=0, latched operands=0, timer=0.
REQ-021 Reset mid-operation abandons the transaction silently; units tolerate u_req dropping before u_ack.

Configuration
REQ-022 Macro PCPI_DISPATCH_TIMEOUT_EN, when defined: a counter SHALL clear on entry to ISSUE and increment in ISSUE and WAIT.
REQ-023 With the macro defined: on reaching TIMEOUT the FSM goes to RESP with pcpi_wr=0, pcpi_rd=0 and u_req dropped, and a sticky timeout flag output is cleared only by reset.
REQ-024 Without the macro: no counter and no flag port; the FSM waits indefinitely.

Structure
REQ-025 Package pcpi_pkg SHALL hold: the state enum, OPCODE_CUSTOM0, the funct7/funct3 field position constants, and the PCPI width constant (32).
REQ-026 Sub-module pcpi_decode (combinational) SHALL produce claim and unit index from insn and N_UNITS; all sequencing stays in pcpi_dispatch.

Verification
REQ-027 Scenario: insn=0x0200_000B (funct7=1), rs1=5, rs2=3, unit1 acks at cycle 1 and returns done with 0x6 at cycle 3 -> pcpi_ready=1, pcpi_wr=1, rd=0x6 at cycle 4; u_req=0b0010 only.
REQ-028 Scenario: opcode 0x33, or funct7=4 with N_UNITS=4 -> no u_req, pcpi_wait=0, pcpi_ready=0 for 20 cycles.
REQ-029 Scenario: same-cycle ack+done from unit0 with res 0xDEADBEEF -> pcpi_ready at cycle 2 with rd=0xDEADBEEF; u_done from a non-selected unit is ignored.
REQ-030 Scenario: pcpi_valid drops in WAIT -> IDLE next cycle; a late u_done yields no pcpi_ready; the next instruction completes normally.
REQ-031 Scenario: reset asserted in WAIT -> all outputs 0 at the next edge; reset released, then a new instruction completes.
REQ-032 Scenario: timeout build, TIMEOUT=64, unit never finishes -> pcpi_ready=1 with wr=0 exactly 64 cycles after ISSUE entry; flag set and held.
